// File: rtl/board_io_pkg.sv
// Shared constants for the board I/O MMIO peripheral: register word indices,
// bus data width and the debounce counter sizing helper.
package board_io_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] REG_SW   = 2'd0;
    localparam logic [1:0] REG_LED  = 2'd1;
    localparam logic [1:0] REG_CHG  = 2'd2;
    localparam logic [1:0] REG_MASK = 2'd3;

    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-flop synchroniser, stability counter, debounced state
// and a single-cycle change pulse when a new level is accepted.
module sw_debounce
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic state,
    output logic chg
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            state <= 1'b0;
            cnt   <= '0;
            chg   <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
            chg  <= 1'b0;
            // any cycle where the synced level matches the state restarts the count
            if (sync == state) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                state <= sync;
                cnt   <= '0;
                chg   <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_io_mmio.sv
// Memory-mapped board I/O: debounced switches with W1C change flags, LED register.
// Optional interrupt and IRQ_MASK register are built when BOARD_IO_IRQ_EN is defined.
module board_io_mmio
    import board_io_pkg::*;
#(
    parameter int SW_W            = 3,
    parameter int LED_W           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SW_W-1:0]   sw_pin,
    output logic [LED_W-1:0]  led,
    input  logic [3:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    input  logic              re,
    output logic [DATA_W-1:0] rdata
`ifdef BOARD_IO_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic [SW_W-1:0]   sw_state;
    logic [SW_W-1:0]   chg;
    logic [SW_W-1:0]   chg_flags;
    logic [SW_W-1:0]   chg_clr;
    logic [1:0]        wsel;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_bits;

    assign wsel        = addr[3:2];
    assign unused_bits = ^{addr[1:0], wdata};

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .pin   (sw_pin[i]),
            .state (sw_state[i]),
            .chg   (chg[i])
        );
    end

`ifdef BOARD_IO_IRQ_EN
    logic [SW_W-1:0] irq_mask;
`endif

    always_comb begin
        chg_clr = (we && wsel == REG_CHG) ? wdata[SW_W-1:0] : '0;
    end

    always_comb begin
        rd_mux = '0;
        case (wsel)
            REG_SW:   rd_mux[SW_W-1:0]  = sw_state;
            REG_LED:  rd_mux[LED_W-1:0] = led;
            REG_CHG:  rd_mux[SW_W-1:0]  = chg_flags;
            default: begin
`ifdef BOARD_IO_IRQ_EN
                rd_mux[SW_W-1:0] = irq_mask;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led       <= '0;
            chg_flags <= '0;
            rdata     <= '0;
        end else begin
            if (we && wsel == REG_LED) begin
                led <= wdata[LED_W-1:0];
            end
            // a set pulse in the same cycle as a W1C clear takes priority
            chg_flags <= (chg_flags & ~chg_clr) | chg;
            if (re) begin
                rdata <= rd_mux;
            end
        end
    end

`ifdef BOARD_IO_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (we && wsel == REG_MASK) begin
                irq_mask <= wdata[SW_W-1:0];
            end
            irq <= |(chg_flags & irq_mask);
        end
    end
`endif

endmodule

// File: tb/tb_board_io_mmio.sv
// Directed self-checking bench for board_io_mmio (SW_W=3, LED_W=4, DEBOUNCE_CYCLES=4).
// Irq checks are compiled in only when BOARD_IO_IRQ_EN is defined.
module tb_board_io_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sw_pin;
    logic [3:0]  led;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
`ifdef BOARD_IO_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    board_io_mmio #(
        .SW_W            (3),
        .LED_W           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sw_pin (sw_pin),
        .led    (led),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .re     (re),
        .rdata  (rdata)
`ifdef BOARD_IO_IRQ_EN
        ,
        .irq    (irq)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a);
        addr = a;
        re   = 1'b1;
        tick();
        re   = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    initial begin
        reset  = 1'b0;
        sw_pin = 3'b000;
        addr   = 4'h0;
        wdata  = 32'h0;
        we     = 1'b0;
        re     = 1'b0;
        repeat (3) tick();
        check("reset_led", {28'h0, led}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
`ifdef BOARD_IO_IRQ_EN
        check("reset_irq", {31'h0, irq}, 32'h0);
`endif
        reset = 1'b1;
        tick();

        rd(4'h0);
        check("rd_sw_idle", rdata, 32'h0);
        check("led_idle", {28'h0, led}, 32'h0);

        // pin edge lands between edges; state must flip on the 6th edge after it
        sw_pin = 3'b101;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sw_state_pending", {29'h0, dut.sw_state}, 32'h0);
        end
        tick();
        check("sw_state_6cyc", {29'h0, dut.sw_state}, 32'h5);
        tick();
        rd(4'h8);
        check("rd_chg_5", rdata, 32'h5);
        rd(4'h0);
        check("rd_sw_5", rdata, 32'h5);

        // 3-cycle glitch on channel 1 must be rejected
        sw_pin = 3'b111;
        repeat (3) tick();
        sw_pin = 3'b101;
        repeat (10) tick();
        check("glitch_state", {29'h0, dut.sw_state}, 32'h5);
        rd(4'h8);
        check("glitch_flags", rdata, 32'h5);

        wr(4'h4, 32'hFFFF_FFFA);
        check("led_write", {28'h0, led}, 32'hA);
        rd(4'h4);
        check("rd_led", rdata, 32'h0000_000A);
        wr(4'h0, 32'hFFFF_FFFF);
        rd(4'h1);
        check("sw_ro_addr_lsb_ignored", rdata, 32'h5);
        repeat (3) tick();
        check("rdata_hold", rdata, 32'h5);

        // same-cycle write and read: old value returned, write commits
        addr  = 4'h4;
        wdata = 32'h3;
        we    = 1'b1;
        re    = 1'b1;
        tick();
        we    = 1'b0;
        re    = 1'b0;
        check("we_re_old", rdata, 32'hA);
        check("we_re_led", {28'h0, led}, 32'h3);

        // channel 0 falls; its chg pulse is live on the same edge as a W1C of bit 0
        sw_pin = 3'b100;
        repeat (6) tick();
        check("ch0_fall_state", {29'h0, dut.sw_state}, 32'h4);
        wr(4'h8, 32'h1);
        rd(4'h8);
        check("set_wins", rdata, 32'h5);
        wr(4'h8, 32'h0);
        rd(4'h8);
        check("w1c_zero_noop", rdata, 32'h5);
        wr(4'h8, 32'h5);
        rd(4'h8);
        check("w1c_clear", rdata, 32'h0);

`ifdef BOARD_IO_IRQ_EN
        wr(4'hC, 32'hFFFF_FFFA);
        rd(4'hC);
        check("rd_mask", rdata, 32'h2);
        sw_pin = 3'b110;
        repeat (7) tick();
        check("irq_before", {31'h0, irq}, 32'h0);
        tick();
        check("irq_set", {31'h0, irq}, 32'h1);
        wr(4'h8, 32'h2);
        check("irq_still", {31'h0, irq}, 32'h1);
        tick();
        check("irq_clear", {31'h0, irq}, 32'h0);
        sw_pin = 3'b100;
        repeat (10) tick();
        wr(4'h8, 32'h7);
`else
        rd(4'hC);
        check("rd_reserved", rdata, 32'h0);
`endif

        // reset in the middle of a pending debounce count
        wr(4'h4, 32'h9);
        rd(4'h0);
        sw_pin = 3'b101;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        check("midreset_led", {28'h0, led}, 32'h0);
        check("midreset_rdata", rdata, 32'h0);
        check("midreset_state", {29'h0, dut.sw_state}, 32'h0);
        sw_pin = 3'b000;
        tick();
        reset = 1'b1;
        repeat (8) tick();
        rd(4'h0);
        check("post_reset_sw", rdata, 32'h0);
        rd(4'h8);
        check("post_reset_chg", rdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
